dot_product_mac: RTL and testbench

Streaming multi-lane dot-product engine, the parametrised successor of the single-lane unsigned×signed multiplier. Each beat carries LANES unsigned activations and LANES signed weights. The lane products are summed and accumulated across beats until a last-marked beat closes the vector. The signed result is then presented on a valid/ready output with optional saturation and an overflow flag. It sits between the activation/weight fetch buffers and the post-processing (bias/ReLU) stage.

---
 rtl/dot_product_mac_pkg.sv | 27 ++
 rtl/dp_lane_mul.sv | 14 +
 rtl/dot_product_mac.sv | 162 ++++++++++++++++
 tb/tb_dot_product_mac.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_mac_pkg.sv
// rtl/dot_product_mac_pkg.sv - shared types, widths and saturation helpers for dot_product_mac
package dot_product_mac_pkg;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int PROD_W = 17;

    // Width of the per-beat lane sum: one product plus carry growth of the tree.
    function automatic int sum_w(input int lanes);
        return PROD_W + $clog2(lanes);
    endfunction

    // Largest positive w-bit two's-complement value (zero-extended to 64 bits).
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative w-bit value; only the low w bits are meaningful.
    function automatic logic [63:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/dp_lane_mul.sv
// rtl/dp_lane_mul.sv - combinational unsigned x signed 8-bit lane multiplier
// Ports: a (unsigned activation), b (signed weight), p (17-bit signed product).
module dp_lane_mul
    import dot_product_mac_pkg::*;
(
    input  logic [7:0]               a,
    input  logic [7:0]               b,
    output logic signed [PROD_W-1:0] p
);

    // a is zero-extended so 255 stays positive; b is sign-extended.
    assign p = PROD_W'($signed({1'b0, a})) * PROD_W'($signed(b));

endmodule

// File: rtl/dot_product_mac.sv
// rtl/dot_product_mac.sv - streaming multi-lane dot-product accumulator with saturation
// Ports: clk, rst_n (async low), clr (sync soft clear), sat_en;
//        in_valid/in_ready/in_a/in_b/in_last input beat stream;
//        res_valid/res_ready/res/res_ovf/res_beats result handshake.
module dot_product_mac
    import dot_product_mac_pkg::*;
#(
    parameter int LANES = 4,
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    sat_en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*8-1:0]      in_a,
    input  logic [LANES*8-1:0]      in_b,
    input  logic                    in_last,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [ACC_W-1:0] res,
    output logic                    res_ovf,
    output logic [CNT_W-1:0]        res_beats
);

    localparam int SUM_W = sum_w(LANES);
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

    state_t                    state;
    logic                      accept;

    // Input capture stage
    logic                      s0_valid;
    logic                      s0_last;
    logic [LANES*8-1:0]        s0_a;
    logic [LANES*8-1:0]        s0_b;

    // Product stage
    logic signed [PROD_W-1:0]  prod    [LANES];
    logic signed [PROD_W-1:0]  s1_prod [LANES];
    logic                      s1_valid;
    logic                      s1_last;

    // Accumulate stage
    logic [ACC_W-1:0]          acc;
    logic                      ovf;
    logic [CNT_W-1:0]          beats;
    logic signed [SUM_W-1:0]   lane_sum;
    logic [ACC_W:0]            add_full;
    logic                      add_ovf;
    logic [ACC_W-1:0]          acc_next;

    assign in_ready  = (state == ACC);
    assign accept    = in_valid && in_ready;
    assign res       = $signed(acc);
    assign res_ovf   = ovf;
    assign res_beats = beats;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dp_lane_mul u_mul (
            .a (s0_a[8*i +: 8]),
            .b (s0_b[8*i +: 8]),
            .p (prod[i])
        );
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + SUM_W'(s1_prod[i]);
        end
    end

    // One guard bit: the top two bits disagree exactly when the true sum
    // does not fit in ACC_W bits; the guard bit then carries the true sign.
    always_comb begin
        add_full = {acc[ACC_W-1], acc}
                 + {{(ACC_W + 1 - SUM_W){lane_sum[SUM_W-1]}}, lane_sum};
        add_ovf  = add_full[ACC_W] ^ add_full[ACC_W-1];
        acc_next = add_full[ACC_W-1:0];
        if (add_ovf && sat_en) begin
            acc_next = add_full[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            s0_valid  <= 1'b0;
            s0_last   <= 1'b0;
            s0_a      <= '0;
            s0_b      <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_prod[i] <= '0;
            end
            acc       <= '0;
            ovf       <= 1'b0;
            beats     <= '0;
            res_valid <= 1'b0;
        end else if (clr) begin
            state     <= ACC;
            s0_valid  <= 1'b0;
            s1_valid  <= 1'b0;
            acc       <= '0;
            ovf       <= 1'b0;
            beats     <= '0;
            res_valid <= 1'b0;
        end else begin
            s0_valid <= accept;
            s0_last  <= accept && in_last;
            if (accept) begin
                s0_a <= in_a;
                s0_b <= in_b;
            end

            s1_valid <= s0_valid;
            s1_last  <= s0_valid && s0_last;
            if (s0_valid) begin
                s1_prod <= prod;
            end

            if (s1_valid) begin
                acc <= acc_next;
                ovf <= ovf | add_ovf;
                if (beats != {CNT_W{1'b1}}) begin
                    beats <= beats + CNT_W'(1);
                end
            end

            case (state)
                ACC: begin
                    if (accept && in_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (s1_valid && s1_last) begin
                        state     <= HOLD;
                        res_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    // Pipeline is empty here, so clearing cannot race an accumulate.
                    if (res_ready) begin
                        state     <= ACC;
                        res_valid <= 1'b0;
                        acc       <= '0;
                        ovf       <= 1'b0;
                        beats     <= '0;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_mac.sv
// tb/tb_dot_product_mac.sv - self-checking bench for dot_product_mac
module tb_dot_product_mac;

    localparam int LANES = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic sat_en = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic [LANES*8-1:0] in_a = '0;
    logic [LANES*8-1:0] in_b = '0;
    logic res_ready = 1'b0;

    logic in_ready32, res_valid32, res_ovf32;
    logic signed [31:0] res32;
    logic [15:0] beats32;
    logic in_ready20, res_valid20, res_ovf20;
    logic signed [19:0] res20;
    logic [15:0] beats20;

    always #5 clk = ~clk;

    dot_product_mac #(.LANES(LANES), .ACC_W(32), .CNT_W(16)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .sat_en(sat_en),
        .in_valid(in_valid), .in_ready(in_ready32), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .res_valid(res_valid32), .res_ready(res_ready),
        .res(res32), .res_ovf(res_ovf32), .res_beats(beats32)
    );

    dot_product_mac #(.LANES(LANES), .ACC_W(20), .CNT_W(16)) u_dut20 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .sat_en(sat_en),
        .in_valid(in_valid), .in_ready(in_ready20), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .res_valid(res_valid20), .res_ready(res_ready),
        .res(res20), .res_ovf(res_ovf20), .res_beats(beats20)
    );

    typedef struct {
        longint r32;
        bit     o32;
        longint r20;
        bit     o20;
        int     beats;
    } exp_t;

    exp_t exp_q[$];
    int   va[16][LANES];
    int   vb[16][LANES];
    int   tests = 0;
    int   fails = 0;
    bit   rr_auto = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: accumulate beat sums in wide arithmetic, then apply the
    // w-bit wrap or clamp rule after every beat, tracking sticky overflow.
    task automatic model(input int k, input bit sat, input int w,
                         output longint r, output bit ovf);
        longint acc = 0;
        longint mx = (longint'(1) << (w - 1)) - 1;
        longint mn = -mx - 1;
        ovf = 1'b0;
        for (int j = 0; j < k; j++) begin
            longint s = 0;
            for (int i = 0; i < LANES; i++) s += longint'(va[j][i]) * longint'(vb[j][i]);
            acc += s;
            if (acc > mx) begin
                ovf = 1'b1;
                acc = sat ? mx : acc - 2 * (mx + 1);
            end else if (acc < mn) begin
                ovf = 1'b1;
                acc = sat ? mn : acc + 2 * (mx + 1);
            end
        end
        r = acc;
    endtask

    task automatic fill_const(input int k, input int a, input int b);
        for (int j = 0; j < k; j++)
            for (int i = 0; i < LANES; i++) begin
                va[j][i] = a;
                vb[j][i] = b;
            end
    endtask

    task automatic fill_rand(input int k);
        for (int j = 0; j < k; j++)
            for (int i = 0; i < LANES; i++) begin
                va[j][i] = int'($urandom_range(0, 255));
                vb[j][i] = int'($urandom_range(0, 255)) - 128;
            end
    endtask

    task automatic set_beat(input int j, input bit last);
        for (int i = 0; i < LANES; i++) begin
            in_a[8*i +: 8] = 8'(va[j][i]);
            in_b[8*i +: 8] = 8'(vb[j][i]);
        end
        in_last  = last;
        in_valid = 1'b1;
    endtask

    task automatic push_exp(input int k, input bit sat);
        exp_t e;
        model(k, sat, 32, e.r32, e.o32);
        model(k, sat, 20, e.r20, e.o20);
        e.beats = k;
        exp_q.push_back(e);
    endtask

    // Drives beats 0..nsend-1 of a k-beat vector; in_last only on beat k-1.
    task automatic send_vector(input int k, input int nsend, input bit sat,
                               input bit push, input int maxb);
        int cyc = 0;
        @(negedge clk);
        while (!in_ready32 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (!in_ready32) chk("timeout_idle", 0, 1);
        sat_en = sat;
        if (push) push_exp(k, sat);
        @(posedge clk);
        #1;
        for (int j = 0; j < nsend; j++) begin
            int w = 0;
            repeat ($urandom_range(0, maxb)) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            set_beat(j, j == k - 1);
            @(negedge clk);
            while (!in_ready32 && w < 300) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready32) chk("timeout_beat", 0, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result();
        int cyc = 0;
        @(negedge clk);
        while (!res_valid32 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!res_valid32) chk("timeout_result", 0, 1);
    endtask

    task automatic handshake();
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, longint'(in_ready32), 1);
        chk({tag, "_res_valid"}, longint'(res_valid32), 0);
        chk({tag, "_res"}, res32, 0);
        chk({tag, "_res20"}, res20, 0);
        chk({tag, "_ovf"}, longint'(res_ovf32), 0);
        chk({tag, "_beats"}, longint'(beats32), 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (rr_auto) res_ready = ($urandom_range(0, 3) != 0);
    end

    // Per-cycle compare against the head of the expected-result queue.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("lockstep_valid", longint'(res_valid20), longint'(res_valid32));
            chk("lockstep_ready", longint'(in_ready20), longint'(in_ready32));
            if (res_valid32) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("res32", res32, exp_q[0].r32);
                    chk("ovf32", longint'(res_ovf32), longint'(exp_q[0].o32));
                    chk("res20", res20, exp_q[0].r20);
                    chk("ovf20", longint'(res_ovf20), longint'(exp_q[0].o20));
                    chk("beats32", longint'(beats32), longint'(exp_q[0].beats));
                    chk("beats20", longint'(beats20), longint'(exp_q[0].beats));
                    chk("in_ready_hold", longint'(in_ready32), 0);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && res_valid32 && res_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end

    initial begin
        longint r;
        bit     o;

        #2;
        check_reset_outputs("reset");
        #10;
        rst_n = 1'b1;

        // Pin the model against hand-computed values.
        fill_const(5, 255, 127);
        model(5, 1'b1, 20, r, o);
        chk("model_sat20", r, 524287);
        model(5, 1'b0, 20, r, o);
        chk("model_wrap20", r, -400876);
        chk("model_wrap20_ovf", longint'(o), 1);

        // Single beat, latency, then backpressure.
        @(posedge clk);
        #1;
        for (int i = 0; i < LANES; i++) begin
            va[0][i] = i + 1;
            vb[0][i] = 1;
        end
        sat_en = 1'b0;
        push_exp(1, 1'b0);
        set_beat(0, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("lat_e0_valid", longint'(res_valid32), 0);
        @(posedge clk);
        #1;
        chk("lat_e1_valid", longint'(res_valid32), 0);
        @(posedge clk);
        #1;
        chk("lat_e2_valid", longint'(res_valid32), 1);
        chk("single_res", res32, 10);
        chk("single_beats", longint'(beats32), 1);
        chk("single_ovf", longint'(res_ovf32), 0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_res_stable", res32, 10);
            chk("bp_in_ready", longint'(in_ready32), 0);
            chk("bp_valid", longint'(res_valid32), 1);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("post_hs_in_ready", longint'(in_ready32), 1);
        chk("post_hs_valid", longint'(res_valid32), 0);
        fill_const(1, 1, 2);
        send_vector(1, 1, 1'b0, 1'b1, 0);
        wait_result();
        chk("next_vec_res", res32, 8);
        handshake();

        // Extremes.
        fill_const(3, 255, -128);
        send_vector(3, 3, 1'b0, 1'b1, 0);
        wait_result();
        chk("ext_res", res32, -391680);
        chk("ext_beats", longint'(beats32), 3);
        chk("ext_ovf", longint'(res_ovf32), 0);
        handshake();

        // 20-bit accumulator overflow, saturating then wrapping.
        fill_const(5, 255, 127);
        send_vector(5, 5, 1'b1, 1'b1, 0);
        wait_result();
        chk("sat20_res", res20, 524287);
        chk("sat20_ovf", longint'(res_ovf20), 1);
        handshake();
        fill_const(5, 255, 127);
        send_vector(5, 5, 1'b0, 1'b1, 1);
        wait_result();
        chk("wrap20_res", res20, -400876);
        chk("wrap20_ovf", longint'(res_ovf20), 1);
        handshake();

        // Soft clear after 2 of 4 beats, with a 3rd beat offered alongside clr.
        fill_rand(4);
        send_vector(4, 2, 1'b0, 1'b0, 0);
        set_beat(2, 1'b0);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_res", res32, 0);
        chk("clr_beats", longint'(beats32), 0);
        chk("clr_in_ready", longint'(in_ready32), 1);
        repeat (6) @(posedge clk);
        #1;
        chk("clr_no_result", longint'(res_valid32), 0);
        chk("clr_res_after_drain", res32, 0);
        fill_const(1, 1, 1);
        send_vector(1, 1, 1'b0, 1'b1, 0);
        wait_result();
        chk("clr_next_res", res32, 4);
        chk("clr_next_beats", longint'(beats32), 1);
        handshake();

        // Asynchronous reset mid-vector.
        fill_rand(4);
        send_vector(4, 2, 1'b0, 1'b0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Randomized vectors with bubbles and random consumer stalls.
        rr_auto = 1'b1;
        for (int v = 0; v < 40; v++) begin
            int k = int'($urandom_range(1, 6));
            fill_rand(k);
            send_vector(k, k, 1'($urandom_range(0, 1)), 1'b1, 2);
        end
        rr_auto = 1'b0;
        #1;
        res_ready = 1'b1;
        begin
            int cyc = 0;
            while (exp_q.size() != 0 && cyc < 200) begin
                @(posedge clk);
                cyc++;
            end
        end
        #2;
        chk("queue_drained", longint'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
